// File: rtl/branch_target_predictor_pkg.sv
// branch_target_predictor_pkg: shared BTB defaults, FSM states and direction-counter encodings
package branch_target_predictor_pkg;
  localparam int BTB_ENTRIES = 64;
  localparam int BTB_TAG_BITS = 10;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT = 2'b01;
  localparam logic [1:0] WEAK_T = 2'b10;
  localparam logic [1:0] STRONG_T = 2'b11;
endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating direction counter
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] counter,
  input  logic       taken,
  output logic [1:0] nextCounter
);
  always_comb
    nextCounter = taken ? ((counter == STRONG_T) ? counter : counter + 2'd1)
                        : ((counter == STRONG_NT) ? counter : counter - 2'd1);
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit direction counters and a valid-clearing init sequencer
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int PC_WIDTH = 32,
  parameter int TAG_BITS = BTB_TAG_BITS,
  parameter logic [1:0] ALLOC_COUNTER = WEAK_T
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lookupValid,
  input  logic [PC_WIDTH-1:0] lookupPC,
  output logic                branchPredictValid,
  output logic [PC_WIDTH-1:0] branchPredictData,
  input  logic                updateValid,
  input  logic [PC_WIDTH-1:0] updatePC,
  input  logic                updateTaken,
  input  logic [PC_WIDTH-1:0] updateTarget,
  input  logic                invalidateAll,
  output logic                predictorReady
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : gBadEntries
    $error("ENTRIES must be a power of two >= 2");
  end
  if (IDX_BITS + TAG_BITS + 2 > PC_WIDTH) begin : gBadWidth
    $error("IDX_BITS + TAG_BITS + 2 exceeds PC_WIDTH");
  end
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          counter;
  } btbEntry_;
  btbEntry_ btbTable [ENTRIES];
  logic [0:0] state;
  logic [IDX_BITS-1:0] initCount;
  logic [IDX_BITS-1:0] lookupIdx, updateIdx;
  logic [TAG_BITS-1:0] lookupTag, updateTag;
  btbEntry_ lookupEntry, updateEntry;
  logic updateHit;
  logic [1:0] nextCounter;
  logic unusedPcBits;
  assign unusedPcBits = ^{lookupPC, updatePC};
  assign lookupIdx = lookupPC[IDX_BITS+1:2];
  assign lookupTag = lookupPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign updateIdx = updatePC[IDX_BITS+1:2];
  assign updateTag = updatePC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign lookupEntry = btbTable[lookupIdx];
  assign updateEntry = btbTable[updateIdx];
  assign updateHit = updateEntry.valid && updateEntry.tag == updateTag;
  assign predictorReady = state == READY;
  // Reads the registered table, so a same-cycle update is not visible here
  assign branchPredictValid = predictorReady && lookupValid && lookupEntry.valid &&
                              lookupEntry.tag == lookupTag && lookupEntry.counter[1];
  assign branchPredictData = branchPredictValid ? lookupEntry.target : '0;
  sat_counter2 uSatCounter (
    .counter     (updateEntry.counter),
    .taken       (updateTaken),
    .nextCounter (nextCounter)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      initCount <= '0;
    end else if (invalidateAll) begin
      state <= INIT;
      initCount <= '0;
    end else if (state == INIT) begin
      btbTable[initCount].valid <= 1'b0;
      initCount <= initCount + 1'b1;
      if (initCount == IDX_BITS'(ENTRIES - 1)) state <= READY;
    end else if (updateValid) begin
      if (updateHit) begin
        btbTable[updateIdx].counter <= nextCounter;
        if (updateTaken) btbTable[updateIdx].target <= updateTarget;
      end else if (updateTaken) begin
        btbTable[updateIdx] <= '{valid: 1'b1, tag: updateTag, target: updateTarget,
                                 counter: ALLOC_COUNTER};
      end
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench against an arithmetic BTB reference model
module tb_branch_target_predictor;
  localparam int ENTRIES = 64;
  localparam int IDXB = 6;
  localparam int TAGB = 10;
  logic clock = 0, reset = 1, lookupValid = 0, updateValid = 0, updateTaken = 0, invalidateAll = 0;
  logic [31:0] lookupPC = 0, updatePC = 0, updateTarget = 0;
  logic branchPredictValid, predictorReady;
  logic [31:0] branchPredictData;
  always #5 clock = ~clock;
  branch_target_predictor #(.ENTRIES(ENTRIES), .PC_WIDTH(32), .TAG_BITS(TAGB), .ALLOC_COUNTER(2'b10)) dut (
    .clock(clock), .reset(reset), .lookupValid(lookupValid), .lookupPC(lookupPC),
    .branchPredictValid(branchPredictValid), .branchPredictData(branchPredictData),
    .updateValid(updateValid), .updatePC(updatePC), .updateTaken(updateTaken),
    .updateTarget(updateTarget), .invalidateAll(invalidateAll), .predictorReady(predictorReady)
  );
  typedef struct {logic r; logic v; logic [31:0] d; int cyc;} exp_t;
  exp_t expq[$];
  int checks = 0, failures = 0, cyc = 0;
  int initLeft = ENTRIES;
  bit mValid[ENTRIES];
  int mTag[ENTRIES], mCtr[ENTRIES];
  logic [31:0] mTarget[ENTRIES];
  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic int tagOf(input logic [31:0] pc);
    return int'((pc >> (2 + IDXB)) % (1 << TAGB));
  endfunction
  // Expected outputs use the table before this cycle's edge; then the edge is applied to the model
  task automatic cycle(input logic rs, input logic inv, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic ut, input logic [31:0] upc, input logic [31:0] utg);
    exp_t e;
    int li, ui;
    reset = rs; invalidateAll = inv; lookupValid = lv; lookupPC = lpc;
    updateValid = uv; updateTaken = ut; updatePC = upc; updateTarget = utg;
    li = idxOf(lpc);
    e.r = initLeft == 0;
    e.v = e.r && lv && mValid[li] && mTag[li] == tagOf(lpc) && mCtr[li] >= 2;
    e.d = e.v ? mTarget[li] : 32'h0;
    e.cyc = cyc;
    expq.push_back(e);
    if (rs || inv) begin
      initLeft = ENTRIES;
      for (int i = 0; i < ENTRIES; i++) mValid[i] = 0;
    end else if (initLeft > 0) begin
      initLeft--;
    end else if (uv) begin
      ui = idxOf(upc);
      if (mValid[ui] && mTag[ui] == tagOf(upc)) begin
        mCtr[ui] = ut ? (mCtr[ui] < 3 ? mCtr[ui] + 1 : 3) : (mCtr[ui] > 0 ? mCtr[ui] - 1 : 0);
        if (ut) mTarget[ui] = utg;
      end else if (ut) begin
        mValid[ui] = 1; mTag[ui] = tagOf(upc); mTarget[ui] = utg; mCtr[ui] = 2;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic look(input logic [31:0] pc);
    cycle(0, 0, 1, pc, 0, 0, 0, 0);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    cycle(0, 0, 0, 0, 1, t, pc, tgt);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks += 3;
        if (predictorReady !== e.r) begin
          failures++;
          $display("FAIL ready cyc=%0d got=%b want=%b", e.cyc, predictorReady, e.r);
        end
        if (branchPredictValid !== e.v) begin
          failures++;
          $display("FAIL predValid cyc=%0d pc=%h got=%b want=%b", e.cyc, lookupPC, branchPredictValid, e.v);
        end
        if (branchPredictData !== e.d) begin
          failures++;
          $display("FAIL predData cyc=%0d pc=%h got=%h want=%h", e.cyc, lookupPC, branchPredictData, e.d);
        end
      end
    end
  end
  initial begin
    logic [31:0] pc;
    @(posedge clock);
    #1;
    repeat (2) cycle(1, 0, 1, 32'h100, 1, 1, 32'h100, 32'h400);
    repeat (70) look(32'h100);
    cycle(0, 0, 1, 32'h104, 1, 1, 32'h100, 32'h400);
    look(32'h100);
    look(32'h104);
    repeat (2) upd(32'h100, 1, 32'h400);
    upd(32'h100, 0, 0); look(32'h100);
    upd(32'h100, 0, 0); look(32'h100);
    repeat (5) upd(32'h100, 0, 0);
    upd(32'h100, 1, 32'h400); look(32'h100);
    upd(32'h100, 1, 32'h400); look(32'h100);
    look(32'h200);
    upd(32'h200, 0, 0); look(32'h100);
    upd(32'h200, 1, 32'h800); look(32'h200); look(32'h100);
    upd(32'h100, 1, 32'h400);
    cycle(0, 0, 1, 32'h100, 1, 1, 32'h100, 32'h500);
    look(32'h100);
    cycle(0, 1, 1, 32'h100, 0, 0, 0, 0);
    repeat (70) look(32'h100);
    upd(32'h100, 1, 32'h400); look(32'h100);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (29) cycle(0, 0, 1, 32'h100, 1, 1, 32'h100, 32'h900);
    cycle(1, 0, 1, 32'h100, 1, 1, 32'h100, 32'h900);
    repeat (63) cycle(0, 0, 1, 32'h104, 1, 1, 32'h104, 32'h940);
    repeat (3) begin look(32'h100); look(32'h104); end
    for (int i = 0; i < 1500; i++) begin
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) pc |= $urandom & 32'hFFFC_0000;
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) ? pc : (pc ^ 32'h0000_0104), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, pc, $urandom);
    end
    @(negedge clock);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
